// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: datapath width, ALU and
// forwarding select codes, writeback encodings and the EX/MEM record.
package riscv_pkg;

   localparam int XLEN = 32;

   // ALU control codes produced by the ALU decoder
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Forwarding selects from the hazard unit; 2'b11 falls back to the register file
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Writeback result selects, carried through EX untouched
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            mem_write;
      logic [1:0]      result_src;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] write_data;
      logic [XLEN-1:0] pc_plus4;
      logic [4:0]      rd;
   } ex_mem_t;

   function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] rf_val,
                                                input logic [XLEN-1:0] wb_val,
                                                input logic [XLEN-1:0] mem_val);
      logic [XLEN-1:0] v;
      case (sel)
         FWD_WB:  v = wb_val;
         FWD_MEM: v = mem_val;
         default: v = rf_val;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage bundle: ID/EX inputs, hazard-unit controls, fetch redirect
// and EX/MEM register outputs. The master drives the E side, the slave is the stage.
interface execute_stage_if #(parameter int XLEN = 32);

   // valid_e qualifies the EX slot: when 0 the slot is a bubble, it cannot
   // redirect fetch and reaches MEM with valid_m/reg_write_m/mem_write_m low.
   // hold_m freezes the EX/MEM register; the producer must keep the E inputs
   // stable for as long as it wants them consumed.
   logic            valid_e;
   logic            reg_write_e;
   logic            mem_write_e;
   logic            jump_e;
   logic            branch_e;
   logic            alu_src_e;
   logic [1:0]      result_src_e;
   logic [2:0]      alu_control_e;
   logic [XLEN-1:0] rd1_e;
   logic [XLEN-1:0] rd2_e;
   logic [XLEN-1:0] imm_ext_e;
   logic [XLEN-1:0] pc_e;
   logic [XLEN-1:0] pc_plus4_e;
   logic [4:0]      rd_e;
   logic [1:0]      forward_a_e;
   logic [1:0]      forward_b_e;
   logic [XLEN-1:0] result_w;
   logic            hold_m;

   logic            pc_src_e;
   logic [XLEN-1:0] pc_target_e;

   logic            valid_m;
   logic            reg_write_m;
   logic            mem_write_m;
   logic [1:0]      result_src_m;
   logic [XLEN-1:0] alu_result_m;
   logic [XLEN-1:0] write_data_m;
   logic [XLEN-1:0] pc_plus4_m;
   logic [4:0]      rd_m;

   modport master (
      output valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
             result_src_e, alu_control_e, rd1_e, rd2_e, imm_ext_e, pc_e,
             pc_plus4_e, rd_e, forward_a_e, forward_b_e, result_w, hold_m,
      input  pc_src_e, pc_target_e, valid_m, reg_write_m, mem_write_m,
             result_src_m, alu_result_m, write_data_m, pc_plus4_m, rd_m
   );

   modport slave (
      input  valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
             result_src_e, alu_control_e, rd1_e, rd2_e, imm_ext_e, pc_e,
             pc_plus4_e, rd_e, forward_a_e, forward_b_e, result_w, hold_m,
      output pc_src_e, pc_target_e, valid_m, reg_write_m, mem_write_m,
             result_src_m, alu_result_m, write_data_m, pc_plus4_m, rd_m
   );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU: add, sub, and, or, signed slt; unknown codes give 0.
// zero flags an all-zero result for beq resolution.
module alu
   import riscv_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [W-1:0] src_a_i,
   input  logic [W-1:0] src_b_i,
   input  logic [2:0]   alu_control_i,
   output logic [W-1:0] result_o,
   output logic         zero_o
);

   logic lt;

   assign lt = ($signed(src_a_i) < $signed(src_b_i));

   always_comb begin
      result_o = '0;
      case (alu_control_i)
         ALU_ADD: result_o = src_a_i + src_b_i;
         ALU_SUB: result_o = src_a_i - src_b_i;
         ALU_AND: result_o = src_a_i & src_b_i;
         ALU_OR:  result_o = src_a_i | src_b_i;
         ALU_SLT: result_o = {{(W-1){1'b0}}, lt};
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect to fetch and
// the EX/MEM pipeline register with hold and bubble handling.
module execute_stage
   import riscv_pkg::*;
(
   input logic            clk,
   input logic            rst,
   execute_stage_if.slave bus
);

   ex_mem_t         ex_mem_q;
   ex_mem_t         ex_mem_d;

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   // MEM-stage forwarding taps the registered value, which is stable while held
   assign src_a = fwd_mux(bus.forward_a_e, bus.rd1_e, bus.result_w, ex_mem_q.alu_result);
   assign fwd_b = fwd_mux(bus.forward_b_e, bus.rd2_e, bus.result_w, ex_mem_q.alu_result);
   assign src_b = bus.alu_src_e ? bus.imm_ext_e : fwd_b;

   alu #(.W(XLEN)) u_alu (
      .src_a_i       (src_a),
      .src_b_i       (src_b),
      .alu_control_i (bus.alu_control_e),
      .result_o      (alu_result),
      .zero_o        (alu_zero)
   );

   // Only beq exists, so a taken branch is simply a zero difference
   assign bus.pc_src_e    = bus.valid_e & (bus.jump_e | (bus.branch_e & alu_zero));
   assign bus.pc_target_e = bus.pc_e + bus.imm_ext_e;

   always_comb begin
      ex_mem_d = ex_mem_q;
      if (!bus.hold_m) begin
         // A bubble still captures data fields, but its side-effect controls are cleared
         ex_mem_d.valid      = bus.valid_e;
         ex_mem_d.reg_write  = bus.valid_e & bus.reg_write_e;
         ex_mem_d.mem_write  = bus.valid_e & bus.mem_write_e;
         ex_mem_d.result_src = bus.result_src_e;
         ex_mem_d.alu_result = alu_result;
         ex_mem_d.write_data = fwd_b;
         ex_mem_d.pc_plus4   = bus.pc_plus4_e;
         ex_mem_d.rd         = bus.rd_e;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_mem_q <= '0;
      end else begin
         ex_mem_q <= ex_mem_d;
      end
   end

   assign bus.valid_m      = ex_mem_q.valid;
   assign bus.reg_write_m  = ex_mem_q.reg_write;
   assign bus.mem_write_m  = ex_mem_q.mem_write;
   assign bus.result_src_m = ex_mem_q.result_src;
   assign bus.alu_result_m = ex_mem_q.alu_result;
   assign bus.write_data_m = ex_mem_q.write_data;
   assign bus.pc_plus4_m   = ex_mem_q.pc_plus4;
   assign bus.rd_m         = ex_mem_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a vector table for ALU/branch/jump and
// hand sequences for reset, forwarding, hold, bubble and reset-during-hold.
module tb_execute_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   execute_stage_if #(.XLEN(32)) bus ();

   execute_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [2:0]  ctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        alu_src;
      logic        valid;
      logic        branch;
      logic        jump;
      logic        reg_write;
      logic        mem_write;
      logic [4:0]  rd;
      logic        chk_data;
      logic [31:0] exp_alu;
      logic        exp_pc_src;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.valid_e       = 1'b0;
      bus.reg_write_e   = 1'b0;
      bus.mem_write_e   = 1'b0;
      bus.jump_e        = 1'b0;
      bus.branch_e      = 1'b0;
      bus.alu_src_e     = 1'b0;
      bus.result_src_e  = 2'b00;
      bus.alu_control_e = 3'b000;
      bus.rd1_e         = '0;
      bus.rd2_e         = '0;
      bus.imm_ext_e     = '0;
      bus.pc_e          = '0;
      bus.pc_plus4_e    = '0;
      bus.rd_e          = '0;
      bus.forward_a_e   = 2'b00;
      bus.forward_b_e   = 2'b00;
      bus.result_w      = '0;
      bus.hold_m        = 1'b0;
   endtask

   task automatic check_m_zero(input string nm);
      check({nm, ".valid_m"},      {31'd0, bus.valid_m},      32'd0);
      check({nm, ".reg_write_m"},  {31'd0, bus.reg_write_m},  32'd0);
      check({nm, ".mem_write_m"},  {31'd0, bus.mem_write_m},  32'd0);
      check({nm, ".result_src_m"}, {30'd0, bus.result_src_m}, 32'd0);
      check({nm, ".alu_result_m"}, bus.alu_result_m,          32'd0);
      check({nm, ".write_data_m"}, bus.write_data_m,          32'd0);
      check({nm, ".pc_plus4_m"},   bus.pc_plus4_m,            32'd0);
      check({nm, ".rd_m"},         {27'd0, bus.rd_m},         32'd0);
   endtask

   // Simple valid add with register-file operands
   task automatic load_add(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      idle();
      bus.valid_e       = 1'b1;
      bus.reg_write_e   = 1'b1;
      bus.mem_write_e   = 1'b1;
      bus.result_src_e  = 2'b10;
      bus.alu_control_e = 3'b000;
      bus.rd1_e         = a;
      bus.rd2_e         = b;
      bus.rd_e          = rd;
      bus.pc_plus4_e    = 32'h0000_0404;
      step();
   endtask

   task automatic drive(input vec_t v);
      idle();
      bus.alu_control_e = v.ctrl;
      bus.rd1_e         = v.rd1;
      bus.rd2_e         = v.rd2;
      bus.imm_ext_e     = v.imm;
      bus.pc_e          = v.pc;
      bus.pc_plus4_e    = v.pc + 32'd4;
      bus.alu_src_e     = v.alu_src;
      bus.valid_e       = v.valid;
      bus.branch_e      = v.branch;
      bus.jump_e        = v.jump;
      bus.reg_write_e   = v.reg_write;
      bus.mem_write_e   = v.mem_write;
      bus.result_src_e  = 2'b01;
      bus.rd_e          = v.rd;
   endtask

   function automatic vec_t mk(input string nm, input logic [2:0] ctrl,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic alu_src, input logic valid,
                               input logic branch, input logic jump,
                               input logic chk_data, input logic [31:0] exp_alu,
                               input logic exp_pc_src);
      vec_t v;
      v.name = nm; v.ctrl = ctrl; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pc = pc;
      v.alu_src = alu_src; v.valid = valid; v.branch = branch; v.jump = jump;
      v.reg_write = 1'b1; v.mem_write = 1'b1; v.rd = 5'd17;
      v.chk_data = chk_data; v.exp_alu = exp_alu; v.exp_pc_src = exp_pc_src;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vecs.push_back(mk("add",      3'b000, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h200, 0, 1, 0, 0, 1, 32'hFFFF_FFFE, 0));
      vecs.push_back(mk("sub",      3'b001, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h204, 0, 1, 0, 0, 1, 32'hFFFF_FFF8, 0));
      vecs.push_back(mk("and",      3'b010, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h208, 0, 1, 0, 0, 1, 32'h0000_0003, 0));
      vecs.push_back(mk("or",       3'b011, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h20C, 0, 1, 0, 0, 1, 32'hFFFF_FFFB, 0));
      vecs.push_back(mk("slt",      3'b101, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h210, 0, 1, 0, 0, 1, 32'h0000_0001, 0));
      vecs.push_back(mk("code100",  3'b100, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h214, 0, 1, 0, 0, 1, 32'h0000_0000, 0));
      vecs.push_back(mk("code110",  3'b110, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h218, 0, 1, 0, 0, 1, 32'h0000_0000, 0));
      vecs.push_back(mk("code111",  3'b111, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h21C, 0, 1, 0, 0, 1, 32'h0000_0000, 0));
      vecs.push_back(mk("slt_rev",  3'b101, 32'd3, 32'hFFFF_FFFB, 32'h0, 32'h220, 0, 1, 0, 0, 1, 32'h0000_0000, 0));
      vecs.push_back(mk("slt_eq",   3'b101, 32'd5, 32'd5,         32'h0, 32'h224, 0, 1, 0, 0, 1, 32'h0000_0000, 0));
      vecs.push_back(mk("add_imm",  3'b000, 32'h10, 32'hABCD,     32'h20, 32'h228, 1, 1, 0, 0, 1, 32'h0000_0030, 0));
      vecs.push_back(mk("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h22C, 0, 1, 0, 0, 1, 32'h0000_0000, 0));
      vecs.push_back(mk("beq_eq",   3'b001, 32'd9, 32'd9,         32'h20, 32'h100, 0, 1, 1, 0, 1, 32'h0000_0000, 1));
      vecs.push_back(mk("beq_ne",   3'b001, 32'd9, 32'd8,         32'h20, 32'h100, 0, 1, 1, 0, 1, 32'h0000_0001, 0));
      vecs.push_back(mk("br_and0",  3'b010, 32'hF0, 32'h0F,       32'h40, 32'h300, 0, 1, 1, 0, 1, 32'h0000_0000, 1));
      vecs.push_back(mk("jmp_bub",  3'b000, 32'd1, 32'd2,         32'h80, 32'h400, 0, 0, 0, 1, 0, 32'h0000_0000, 0));
      vecs.push_back(mk("br_bub",   3'b001, 32'd9, 32'd9,         32'h80, 32'h404, 0, 0, 1, 0, 0, 32'h0000_0000, 0));
      vecs.push_back(mk("jmp",      3'b000, 32'd1, 32'd2,         32'h80, 32'h408, 0, 1, 0, 1, 1, 32'h0000_0003, 1));

      // Reset with arbitrary inputs, held for two cycles
      idle();
      rst            = 1'b1;
      bus.rd1_e      = 32'h1234_5678;
      bus.rd2_e      = 32'h0BAD_F00D;
      bus.jump_e     = 1'b1;
      bus.branch_e   = 1'b1;
      bus.reg_write_e = 1'b1;
      bus.rd_e       = 5'd31;
      step();
      step();
      check_m_zero("reset");
      check("reset.pc_src_e", {31'd0, bus.pc_src_e}, 32'd0);
      rst = 1'b0;

      // Table: combinational outputs mid-cycle, registered outputs after the edge
      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(negedge clk);
         check({vecs[i].name, ".pc_src_e"}, {31'd0, bus.pc_src_e}, {31'd0, vecs[i].exp_pc_src});
         check({vecs[i].name, ".pc_target_e"}, bus.pc_target_e, vecs[i].pc + vecs[i].imm);
         step();
         check({vecs[i].name, ".valid_m"}, {31'd0, bus.valid_m}, {31'd0, vecs[i].valid});
         check({vecs[i].name, ".reg_write_m"}, {31'd0, bus.reg_write_m}, {31'd0, vecs[i].valid});
         check({vecs[i].name, ".mem_write_m"}, {31'd0, bus.mem_write_m}, {31'd0, vecs[i].valid});
         if (vecs[i].chk_data) begin
            check({vecs[i].name, ".alu_result_m"}, bus.alu_result_m, vecs[i].exp_alu);
            check({vecs[i].name, ".write_data_m"}, bus.write_data_m, vecs[i].rd2);
            check({vecs[i].name, ".pc_plus4_m"}, bus.pc_plus4_m, vecs[i].pc + 32'd4);
            check({vecs[i].name, ".rd_m"}, {27'd0, bus.rd_m}, 32'd17);
            check({vecs[i].name, ".result_src_m"}, {30'd0, bus.result_src_m}, 32'd1);
         end
      end

      // Forwarding: MEM forward on A, WB forward on B, select 11 falls back to RF
      load_add(32'h10, 32'h0, 5'd1);
      check("fwd.setup", bus.alu_result_m, 32'h10);
      idle();
      bus.valid_e = 1'b1; bus.alu_control_e = 3'b001;
      bus.forward_a_e = 2'b10; bus.rd1_e = 32'h999; bus.rd2_e = 32'd4;
      step();
      check("fwd_a_mem.alu_result_m", bus.alu_result_m, 32'hC);
      idle();
      bus.valid_e = 1'b1; bus.alu_control_e = 3'b000;
      bus.forward_b_e = 2'b01; bus.result_w = 32'd7; bus.rd1_e = 32'd0; bus.rd2_e = 32'h55;
      step();
      check("fwd_b_wb.alu_result_m", bus.alu_result_m, 32'd7);
      check("fwd_b_wb.write_data_m", bus.write_data_m, 32'd7);
      idle();
      bus.valid_e = 1'b1; bus.alu_control_e = 3'b000;
      bus.forward_a_e = 2'b11; bus.forward_b_e = 2'b11; bus.result_w = 32'h100;
      bus.rd1_e = 32'd5; bus.rd2_e = 32'd1;
      step();
      check("fwd_11.alu_result_m", bus.alu_result_m, 32'd6);
      check("fwd_11.write_data_m", bus.write_data_m, 32'd1);

      // Hold for three cycles while inputs change; a bubble under hold is ignored
      load_add(32'h55, 32'h11, 5'd5);
      for (int c = 0; c < 3; c++) begin
         idle();
         bus.hold_m = 1'b1;
         bus.valid_e = (c != 1);
         bus.jump_e = 1'b1;
         bus.alu_control_e = 3'b011;
         bus.rd1_e = 32'hA000_0000 + c;
         bus.rd2_e = 32'h0000_0F00;
         bus.rd_e = 5'd9;
         bus.pc_plus4_e = 32'h8888;
         @(negedge clk);
         check($sformatf("hold%0d.pc_src_e", c), {31'd0, bus.pc_src_e}, {31'd0, (c != 1)});
         step();
         check($sformatf("hold%0d.alu_result_m", c), bus.alu_result_m, 32'h66);
         check($sformatf("hold%0d.write_data_m", c), bus.write_data_m, 32'h11);
         check($sformatf("hold%0d.valid_m", c), {31'd0, bus.valid_m}, 32'd1);
         check($sformatf("hold%0d.reg_write_m", c), {31'd0, bus.reg_write_m}, 32'd1);
         check($sformatf("hold%0d.mem_write_m", c), {31'd0, bus.mem_write_m}, 32'd1);
         check($sformatf("hold%0d.rd_m", c), {27'd0, bus.rd_m}, 32'd5);
         check($sformatf("hold%0d.pc_plus4_m", c), bus.pc_plus4_m, 32'h404);
         check($sformatf("hold%0d.result_src_m", c), {30'd0, bus.result_src_m}, 32'd2);
      end

      // Bubble after the hold releases
      idle();
      bus.reg_write_e = 1'b1;
      bus.mem_write_e = 1'b1;
      bus.jump_e = 1'b1;
      @(negedge clk);
      check("bubble.pc_src_e", {31'd0, bus.pc_src_e}, 32'd0);
      step();
      check("bubble.valid_m", {31'd0, bus.valid_m}, 32'd0);
      check("bubble.reg_write_m", {31'd0, bus.reg_write_m}, 32'd0);
      check("bubble.mem_write_m", {31'd0, bus.mem_write_m}, 32'd0);

      // Reset during hold clears everything, and stays cleared while hold persists
      load_add(32'h21, 32'h22, 5'd7);
      check("rsthold.setup", bus.alu_result_m, 32'h43);
      bus.hold_m = 1'b1;
      rst = 1'b1;
      step();
      check_m_zero("rst_in_hold");
      rst = 1'b0;
      step();
      check_m_zero("post_rst_hold");
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RISC-V pipeline, directly downstream of the ALU decoder. It takes the decoded 3-bit ALU control and ID/EX operands, applies hazard-unit forwarding, and performs the ALU operation. It resolves branches and jumps with a same-cycle redirect to fetch, and holds the EX/MEM pipeline register with hold and bubble handling.

## Interface
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_e  in  1  EX slot holds a real instruction (0 = bubble)
- reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e  in  1 each  decoded controls
- result_src_e  in  2  writeback select, passed through
- alu_control_e  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt; other codes yield 0
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  in  XLEN each
- rd_e  in  5  destination register
- forward_a_e, forward_b_e  in  2 each  00 register file, 01 result_w, 10 alu_result_m, 11 treated as 00
- result_w  in  XLEN  writeback-stage result
- hold_m  in  1  freeze EX/MEM register
- pc_src_e  out  1  redirect fetch (combinational)
- pc_target_e  out  XLEN  pc_e + imm_ext_e (combinational)
- valid_m, reg_write_m, mem_write_m  out  1 each  registered
- result_src_m  out  2  registered
- alu_result_m, write_data_m, pc_plus4_m  out  XLEN  registered
- rd_m  out  5  registered

## Operation
- src_a = forward_a mux (rd1_e / result_w / alu_result_m).
- fwd_b = forward_b mux, same sources applied to rd2_e.
- src_b = alu_src_e ? imm_ext_e : fwd_b.
- ALU results, all truncated to XLEN:
  - add: src_a + src_b modulo 2^XLEN.
  - sub: src_a − src_b modulo 2^XLEN.
  - and, or: bitwise.
  - slt: signed compare, result zero-extended 1 or 0.
- zero = (ALU result == 0). Only beq is supported, so branch taken = branch_e & zero.
- pc_src_e = valid_e & (jump_e | (branch_e & zero)). It is independent of hold_m; a repeated redirect while held is harmless.
- pc_target_e is always computed; it is meaningful only when pc_src_e = 1.
- EX/MEM register, evaluated each rising edge in priority order:
  1. rst: all registered outputs become 0.
  2. hold_m: all registered outputs keep their value.
  3. valid_e = 0:
     - valid_m, reg_write_m and mem_write_m become 0.
     - Data fields and result_src_m capture current values; they are don't-care.
  4. Otherwise:
     - valid_m ← 1.
     - Control fields ← their _e inputs.
     - alu_result_m ← ALU result; write_data_m ← fwd_b.
     - rd_m ← rd_e; pc_plus4_m ← pc_plus4_e.
- Forwarding from alu_result_m uses the currently registered value. When held, that value is stable.

## Timing
- ALU result, pc_src_e and pc_target_e: combinational, valid in the same cycle as the E inputs.
- EX to M latency: 1 cycle. Throughput: 1 instruction per cycle when hold_m = 0.
- Reset: every registered output reads 0 in the cycle after rst is sampled high. Reset mid-hold also clears, because reset has priority.
- Combinational outputs are not reset. With valid_e = 0 after reset, pc_src_e = 0.
- Simultaneous hold_m and valid_e = 0: hold wins, and the previous contents are kept.
- Forwarding mux plus ALU plus branch compare is the critical path. It contains no registers.

## Structure
- Shared package `riscv_pkg`:
  - ALU control codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT).
  - Forward select codes (FWD_RF, FWD_WB, FWD_MEM).
  - result_src encodings.
  - XLEN default.
- One sub-module, `alu`: purely combinational, inputs src_a, src_b, alu_control; outputs result and zero.
- The forwarding muxes, branch logic and EX/MEM register live in `execute_stage`.

## Test plan
- Reset: hold rst = 1 for 2 cycles with arbitrary inputs. All _m outputs read 0, and with valid_e = 0, pc_src_e = 0.
- ALU ops, with rd1 = 0xFFFFFFFB (−5), rd2 = 3 and alu_src_e = 0:
  - add gives 0xFFFFFFFE; sub gives 0xFFFFFFF8; and gives 0x3; or gives 0xFFFFFFFB; slt gives 1.
  - Code 100 gives 0.
  - Each value appears on alu_result_m one cycle later.
- Forwarding:
  - forward_a = 10 with alu_result_m = 0x10 and rd2 = 4, sub: next alu_result_m = 0xC.
  - forward_b = 01 with result_w = 7 and rd1 = 0, add: alu_result_m = 7 and write_data_m = 7.
- Branch and jump:
  - beq with rd1 = rd2 = 9, pc_e = 0x100, imm = 0x20: pc_src_e = 1, pc_target_e = 0x120.
  - rd2 = 8: pc_src_e = 0.
  - jump_e = 1 with valid_e = 0: pc_src_e = 0.
- Hold and bubble:
  - hold_m = 1 for 3 cycles while inputs change: _m outputs stay frozen.
  - Then valid_e = 0 for 1 cycle: valid_m, reg_write_m and mem_write_m read 0.
  - rst asserted during the hold: all _m outputs read 0.
